// File: rtl/gshare_global_predictor.sv
// rtl/gshare_global_predictor.sv - gshare direction predictor: PC^GHR indexed counter table, GHR checkpoint repair.
// Optional build macro GSHARE_RW_BYPASS_EN forwards a same-cycle training write to the lookup.
module gshare_global_predictor #(
    parameter int unsigned GlobalPredictorSize      = 1024,
    parameter int unsigned GlobalPredictorIndexBits = 10,
    parameter int unsigned GlobalCtrBits            = 2,
    parameter int unsigned VLEN                     = 64
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                flush_bp_i,
    input  logic                                debug_mode_i,
    input  logic                                req_valid_i,
    input  logic [VLEN-1:0]                     req_pc_i,
    output logic                                pred_valid_o,
    output logic                                pred_taken_o,
    output logic [GlobalPredictorIndexBits-1:0] pred_ghr_o,
    input  logic                                res_valid_i,
    input  logic [VLEN-1:0]                     res_pc_i,
    input  logic                                res_taken_i,
    input  logic                                res_mispredict_i,
    input  logic [GlobalPredictorIndexBits-1:0] res_ghr_i
);

    localparam int unsigned IdxBits = GlobalPredictorIndexBits;
    localparam int unsigned CtrBits = GlobalCtrBits;
    localparam logic [CtrBits-1:0] CtrInit = {1'b0, {(CtrBits-1){1'b1}}};
    localparam logic [CtrBits-1:0] CtrMax  = '1;

    logic [CtrBits-1:0] ctr_q [GlobalPredictorSize];
    logic [CtrBits-1:0] ctr_d [GlobalPredictorSize];
    logic [IdxBits-1:0] ghr_q, ghr_d;
    logic               pred_valid_q, pred_valid_d;
    logic               pred_taken_q, pred_taken_d;
    logic [IdxBits-1:0] pred_ghr_q, pred_ghr_d;

    logic [IdxBits-1:0] lookup_idx;
    logic [IdxBits-1:0] train_idx;
    logic               train_en;
    logic               repair_en;
    logic [CtrBits-1:0] train_ctr;
    logic [CtrBits-1:0] rd_ctr;
    logic               pred_bit;

    // Bit 0 is never part of the index: compressed instructions keep PCs 2-byte aligned.
    assign lookup_idx = req_pc_i[IdxBits:1] ^ ghr_q;
    assign train_idx  = res_pc_i[IdxBits:1] ^ res_ghr_i;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{req_pc_i[VLEN-1:IdxBits+1], req_pc_i[0],
                              res_pc_i[VLEN-1:IdxBits+1], res_pc_i[0]};

    function automatic logic [CtrBits-1:0] sat_update(input logic [CtrBits-1:0] ctr,
                                                      input logic taken);
        logic [CtrBits-1:0] res;
        res = ctr;
        if (taken && ctr != CtrMax) begin
            res = ctr + 1'b1;
        end else if (!taken && ctr != '0) begin
            res = ctr - 1'b1;
        end
        return res;
    endfunction

    always_comb begin
        train_en  = res_valid_i & ~debug_mode_i & ~flush_bp_i;
        repair_en = train_en & res_mispredict_i;
        train_ctr = sat_update(ctr_q[train_idx], res_taken_i);
        rd_ctr    = ctr_q[lookup_idx];
`ifdef GSHARE_RW_BYPASS_EN
        // train_en already excludes flush and debug, so forwarding is off in both.
        if (train_en && (train_idx == lookup_idx)) begin
            rd_ctr = train_ctr;
        end
`endif
        pred_bit = rd_ctr[CtrBits-1];
    end

    always_comb begin
        ctr_d        = ctr_q;
        ghr_d        = ghr_q;
        pred_valid_d = 1'b0;
        pred_taken_d = pred_taken_q;
        pred_ghr_d   = pred_ghr_q;

        if (flush_bp_i) begin
            for (int i = 0; i < GlobalPredictorSize; i++) begin
                ctr_d[i] = CtrInit;
            end
            ghr_d = '0;
        end else begin
            if (train_en) begin
                ctr_d[train_idx] = train_ctr;
            end
            if (req_valid_i) begin
                // A redirecting repair squashes the valid but the lookup itself still happens.
                pred_valid_d = ~repair_en;
                pred_taken_d = pred_bit;
                pred_ghr_d   = ghr_q;
            end
            if (repair_en) begin
                ghr_d = {res_ghr_i[IdxBits-2:0], res_taken_i};
            end else if (req_valid_i && !debug_mode_i) begin
                ghr_d = {ghr_q[IdxBits-2:0], pred_bit};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < GlobalPredictorSize; i++) begin
                ctr_q[i] <= CtrInit;
            end
            ghr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_ghr_q   <= '0;
        end else begin
            for (int i = 0; i < GlobalPredictorSize; i++) begin
                ctr_q[i] <= ctr_d[i];
            end
            ghr_q        <= ghr_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_ghr_q   <= pred_ghr_d;
        end
    end

    assign pred_valid_o = pred_valid_q;
    assign pred_taken_o = pred_taken_q;
    assign pred_ghr_o   = pred_ghr_q;

endmodule
